// File: rtl/phasecalc_pkg.sv
// phasecalc_pkg: shared types and default constants for the phase-calculation
// scheduler. Imported by rr_arbiter and phasecalc_sched.
package phasecalc_pkg;

    // Default number of requesting transducer channel pairs.
    localparam int PC_NUM_CH          = 4;
    // Default number of cycles enable is held per calculation (start cycle included).
    localparam int PC_CALC_CYCLES     = 9;
    // Default maximum wait for done when the timeout feature is built in.
    localparam int PC_TIMEOUT_CYCLES  = 64;

    // Scheduler sequence: IDLE -> START -> RUN -> WAIT_DONE -> ACK -> IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        RUN       = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } sched_state_t;

endpackage

// File: rtl/phasecalc_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick. Returns the first
// requesting index at or after rr_ptr, wrapping modulo NUM_CH. The caller
// registers the result; nothing here holds state.
module rr_arbiter
    import phasecalc_pkg::*;
#(
    parameter int NUM_CH = PC_NUM_CH
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] rr_ptr,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx,
    output logic                      gnt_valid
);

    localparam int IW = $clog2(NUM_CH);

    // Scan offsets from the farthest to the nearest so the nearest requester
    // at or after rr_ptr is the last (and therefore winning) assignment.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_CH]) begin
                gnt_idx   = IW'((int'(rr_ptr) + i) % NUM_CH);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phasecalc_sched.sv
// phasecalc_sched: round-robin scheduler sharing one phase-calculation
// datapath between NUM_CH channels. Grants a channel, drives start/enable
// for CALC_CYCLES cycles, waits for done, then acknowledges the channel.
//
// Optional feature macro: PHASECALC_SCHED_TIMEOUT_EN
//   defined   - WAIT_DONE gives up after TIMEOUT_CYCLES cycles without done and
//               pulses err together with ack.
//   undefined - WAIT_DONE waits indefinitely; err is tied low.
//
// Handshake: req[i] is a level held by channel i until it sees its one-cycle
// ack[i] pulse. req is only looked at in IDLE, so a channel dropping req
// mid-sequence still receives its ack. done is a one-cycle pulse from the
// datapath and is only honoured in WAIT_DONE.
//
// The FSM state register is exported on the state port for observation.
module phasecalc_sched
    import phasecalc_pkg::*;
#(
    parameter int NUM_CH         = PC_NUM_CH,
    parameter int CALC_CYCLES    = PC_CALC_CYCLES,
    parameter int TIMEOUT_CYCLES = PC_TIMEOUT_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      done,
    output logic                      start,
    output logic                      enable,
    output logic [$clog2(NUM_CH)-1:0] sel,
    output logic [NUM_CH-1:0]         ack,
    output logic                      busy,
    output logic                      err,
    output sched_state_t              state
);

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(CALC_CYCLES);
    // RUN lasts CALC_CYCLES-1 cycles (counter CALC_CYCLES-2 down to 0), so
    // together with the START cycle enable is high for CALC_CYCLES cycles.
    localparam logic [CW-1:0] CNT_LOAD = CW'(CALC_CYCLES - 2);

    // Elaboration-time parameter sanity checks.
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("phasecalc_sched: NUM_CH must be in 2..16");
    end
    if (CALC_CYCLES < 2) begin : g_bad_calc_cycles
        $error("phasecalc_sched: CALC_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("phasecalc_sched: TIMEOUT_CYCLES must be at least 1");
    end

    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [IW-1:0] ptr_next;

`ifdef PHASECALC_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Channel after the one being acknowledged, so it gets lowest priority next.
    assign ptr_next = (sel == IW'(NUM_CH - 1)) ? '0 : sel + IW'(1);

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            start  <= 1'b0;
            enable <= 1'b0;
            sel    <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
            cnt    <= '0;
`ifdef PHASECALC_SCHED_TIMEOUT_EN
            err    <= 1'b0;
            to_cnt <= '0;
`endif
        end else begin
            start <= 1'b0;
            ack   <= '0;
`ifdef PHASECALC_SCHED_TIMEOUT_EN
            err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        sel    <= gnt_idx;
                        start  <= 1'b1;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    cnt   <= CNT_LOAD;
`ifdef PHASECALC_SCHED_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= RUN;
                end
                RUN: begin
                    if (cnt == '0) begin
                        enable <= 1'b0;
                        state  <= WAIT_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        ack   <= NUM_CH'(1) << sel;
                        state <= ACK;
                    end
`ifdef PHASECALC_SCHED_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        ack   <= NUM_CH'(1) << sel;
                        err   <= 1'b1;
                        state <= ACK;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
`endif
                end
                ACK: begin
                    rr_ptr <= ptr_next;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    enable <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/phasecalc_sched.md
# phasecalc_sched

Round-robin scheduler that shares the single phase-calculation datapath between `NUM_CH` transducer channel pairs. Each channel raises a request when a sample frame is ready. The scheduler grants one channel, drives the datapath `start`/`enable` sequence, waits for `done`, and acknowledges the channel. It sits between the per-channel capture buffers and the phase-calculation datapath, and replaces the free-running single-shot sequencer for multi-axis operation.

## Interface
- `NUM_CH`, default 4: number of requesting channels, 2..16.
- `CALC_CYCLES`, default 9: cycles `enable` is held per calculation, including the `start` cycle, ≥2.
- `TIMEOUT_CYCLES`, default 64: maximum wait for `done`; used only with the timeout feature.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in NUM_CH: per-channel request, level, held until the matching `ack`.
- `done` in 1: datapath completion pulse.
- `start` out 1: one-cycle pulse that starts the datapath.
- `enable` out 1: datapath enable.
- `sel` out $clog2(NUM_CH): index of the granted channel; drives the datapath input mux.
- `ack` out NUM_CH: one-hot, one-cycle completion pulse to the granted channel.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse issued alongside `ack` when a timeout occurs.

## Operation
- All outputs are registered. Reset values: `start`=0, `enable`=0, `sel`=0, `ack`=0, `busy`=0, `err`=0. Internal round-robin pointer `rr_ptr`=0, cycle counter=0, state=IDLE.
- States: IDLE → START → RUN → WAIT_DONE → ACK → IDLE.
- **IDLE**
  - If any `req` is high, grant the first requesting index at or after `rr_ptr`, with modulo-`NUM_CH` wrap.
  - Latch the index into `sel` and go to START.
  - If no `req` is high, stay in IDLE.
- **START**: one cycle, with `start`=1 and `enable`=1. Load counter with `CALC_CYCLES`-2.
- **RUN**
  - `start`=0, `enable`=1.
  - Decrement the counter each cycle; at 0, go to WAIT_DONE.
  - Total cycles with `enable` high = `CALC_CYCLES`.
- **WAIT_DONE**: `enable`=0. On `done`=1, go to ACK.
- **ACK**
  - One cycle with `ack[sel]`=1.
  - Set `rr_ptr` = `sel`+1, wrapping to 0 after `NUM_CH`-1.
  - Return to IDLE.
- `sel` is stable from START through ACK inclusive.
- `done` is sampled only in WAIT_DONE. A `done` seen in START or RUN is ignored.
- `req` is sampled only in IDLE. Dropping `req` mid-sequence does not abort; `ack` is still issued.
- Counter width is $clog2(`CALC_CYCLES`) bits. `rr_ptr` width equals `sel` width.

## Timing
- `req` high in cycle N while IDLE: `start` high in cycle N+1.
- `enable` is high for cycles N+1 to N+`CALC_CYCLES`.
- `done` high in cycle M while in WAIT_DONE: `ack` high in cycle M+1; IDLE again in cycle M+2.
- Minimum request-to-request spacing is `CALC_CYCLES`+3 cycles, reached when `done` arrives in the first WAIT_DONE cycle.
- The channel just acknowledged has the lowest priority on the next grant, which gives starvation-free service.
- Reset asserted mid-sequence: outputs go to reset values without waiting for a clock edge. No `ack` is issued for the aborted channel.

## Configuration
- Macro: `PHASECALC_SCHED_TIMEOUT_EN`.
- **Defined**:
  - WAIT_DONE counts cycles.
  - After `TIMEOUT_CYCLES` cycles without `done`, go to ACK and pulse `err`=1 together with `ack[sel]`.
  - `rr_ptr` advances as normal.
- **Undefined**:
  - WAIT_DONE waits indefinitely.
  - `err` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `phasecalc_pkg` holds:
  - the `sched_state_t` enum (IDLE, START, RUN, WAIT_DONE, ACK);
  - default constants `PC_NUM_CH`=4 and `PC_CALC_CYCLES`=9.
- Sub-module `rr_arbiter`: combinational round-robin pick, with inputs `req` and `rr_ptr` and outputs `gnt_idx` and `gnt_valid`. The scheduler registers its output.

## Test plan
- Reset, then `req`=4'b0001: `start` pulses 1 cycle after `req` and `enable` stays high 9 cycles. With `done` driven 2 cycles after `enable` falls, `ack`=4'b0001 one cycle after `done`, and `sel`=0 throughout.
- `req`=4'b1111 held high, `done` returned in the first WAIT_DONE cycle every time: grant order is 0, 1, 2, 3, 0, and each grant starts 12 cycles after the previous one.
- Pointer at 3, `req`=4'b0101: the grant wraps to channel 0, then channel 2.
- `done` pulsed during RUN: it is ignored, the scheduler stays in WAIT_DONE, and no `ack` occurs until a later `done`.
- With `PHASECALC_SCHED_TIMEOUT_EN` defined and `done` never driven: `ack[sel]` and `err` pulse together 64 cycles after entry to WAIT_DONE. Without the macro, the scheduler is still in WAIT_DONE after 1000 cycles.
- `reset` asserted asynchronously mid-RUN: `enable`, `start`, `busy` and `ack` drop to 0 before the next clock edge, and the next `req` is granted starting from channel 0.
